clk_switch_ctrl: RTL
====================

Name: clk_switch_ctrl

Overview:
Sequencer that owns the select input of the glitch-free clock mux (clk_switch). It runs on an always-on control clock. It accepts switch requests over a valid/ready handshake and drives sel_clk1. It then waits a fixed settle window, long enough for the mux to hand over in both source domains, before reporting completion. Finally it enforces a minimum dwell time before the next switch is allowed.

Parameters:
- SETTLE_CYC, 8: control-clock cycles between a sel_clk1 change and done. Legal range ≥1.
- DWELL_CYC, 16: cycles after done during which new requests are blocked. Legal range ≥0.
- RST_SEL, 1'b0: sel_clk1 value driven during and after reset.
- CNT_W, 8: switch-counter width. Used only with the optional feature.

Ports:
- clk, input, 1: control clock, always running, independent of clk1/clk2.
- rstn, input, 1: reset, asynchronous, active-low.
- req_valid, input, 1: a switch request is present.
- req_sel, input, 1: requested source. 1 = clk1, 0 = clk2.
- req_ready, output, 1: the controller can accept a request.
- sel_clk1, output, 1: registered select, wired to clk_switch.sel_clk1.
- busy, output, 1: the controller is not in IDLE.
- done, output, 1: one-cycle pulse; the requested source is now in effect.

Behaviour:
- Clocking and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values:
  - state = IDLE, timer = 0.
  - sel_clk1 = RST_SEL.
  - req_ready = 1, busy = 0, done = 0.
- req_ready = (state == IDLE); busy = !req_ready. Both are decoded from registered state only, with no combinational path from req_valid.
- Handshake: a request transfers on a rising edge where req_valid && req_ready. The requester holds req_valid and req_sel stable until transfer; the controller never drops a request that is held.
- States:
  - IDLE:
    - Request with req_sel == sel_clk1 (no-op): stay in IDLE, pulse done in the next cycle, sel_clk1 unchanged, no dwell.
    - Request with req_sel != sel_clk1: at the same edge set sel_clk1 <= req_sel, timer <= SETTLE_CYC-1, go to SETTLE.
  - SETTLE:
    - timer != 0: decrement.
    - timer == 0: done <= 1 for one cycle. Then go to DWELL with timer <= DWELL_CYC-1, or to IDLE directly if DWELL_CYC == 0.
  - DWELL:
    - timer != 0: decrement.
    - timer == 0: go to IDLE.
- Latency from the transfer edge E0:
  - sel_clk1 changes at E0.
  - done is high in the cycle after edge E0+SETTLE_CYC.
  - req_ready returns after edge E0+SETTLE_CYC+DWELL_CYC.
- sel_clk1 changes only on an accepted, non-no-op transfer. It is never altered in SETTLE or DWELL.
- req_valid asserted while busy: ignored (req_ready = 0). The request is accepted on the first IDLE cycle.
- req_sel toggling while req_valid is high and req_ready is low: no effect on the controller.
- Reset mid-SETTLE or mid-DWELL: immediate return to IDLE with sel_clk1 = RST_SEL. No done pulse.
- Timer width: $clog2 of the larger of SETTLE_CYC and DWELL_CYC, minimum 1 bit.

Optional Feature:
- Macro: CLK_SWITCH_CTRL_CNT_EN.
- Defined:
  - Adds output port sw_count [CNT_W-1:0], reset 0.
  - Increments by 1 on each non-no-op accepted request, at the transfer edge.
  - Saturates at all-ones; it does not wrap.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package clk_switch_ctrl_pkg:
  - state enum (IDLE, SETTLE, DWELL), 2 bits.
  - timer-width function tmr_w(settle, dwell).
- Sub-module clk_sw_timer:
  - loadable down-counter with inputs load, load_val, en.
  - output zero flag, reset to 0.
- The top-level controller holds the FSM, the sel_clk1 register and the optional counter.

Test Plan:
1. Reset with RST_SEL = 0, SETTLE_CYC = 8, DWELL_CYC = 16 → sel_clk1 = 0, req_ready = 1, busy = 0, done = 0 throughout reset. Also wire a clk_switch with clk1 = 10 ns and clk2 = 20 ns and check clk_out is glitch-free.
2. Request req_sel = 1, accepted at edge E0 → sel_clk1 = 1 after E0; done high exactly in cycle E0+8..E0+9; req_ready low until edge E0+24, then high.
3. No-op: sel_clk1 = 1, request req_sel = 1 → done pulses in the next cycle; sel_clk1, busy and sw_count unchanged; req_ready stays 1.
4. Back-to-back: req_valid held with req_sel = 0 from E0+2 during a switch → not accepted until E0+24. Second done at E0+32; sw_count = 2.
5. Assert rstn low at E0+5, mid-SETTLE → state IDLE asynchronously, sel_clk1 = RST_SEL, no done pulse. After release, a new request is accepted normally.
6. DWELL_CYC = 0, SETTLE_CYC = 1 → done in the cycle after E0+1 and req_ready high in the same cycle. With CNT_W = 2 and 5 switches, sw_count saturates at 3.

Source files
------------

// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and helpers for the clock-switch sequencer.
//   state_e : FSM encoding (IDLE, SETTLE, DWELL), 2 bits
//   tmr_w   : timer width for given settle/dwell lengths, at least 1 bit
package clk_switch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_e;

    // Width needed to hold (max(settle, dwell) - 1), never less than 1.
    function automatic int tmr_w(input int settle, input int dwell);
        int m;
        m = (settle > dwell) ? settle : dwell;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clk_sw_timer.sv
// Loadable down-counter used for the settle and dwell windows.
// Ports:
//   clk, rstn  : control clock, async active-low reset (count resets to 0)
//   load       : load load_val this cycle (takes priority over en)
//   load_val   : value to load
//   en         : decrement by one when count is non-zero
//   zero       : count == 0
module clk_sw_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer owning the select of the glitch-free clock mux.
// Accepts a switch request over valid/ready, drives sel_clk1, waits a
// settle window before pulsing done, then blocks new requests for a dwell
// window.
// Ports:
//   clk        : always-on control clock
//   rstn       : async active-low reset
//   req_valid  : switch request present
//   req_sel    : requested source (1 = clk1, 0 = clk2)
//   req_ready  : controller is IDLE and can accept a request
//   sel_clk1   : registered mux select
//   busy       : controller not IDLE
//   done       : one-cycle pulse, requested source in effect
//   sw_count   : saturating count of real switches (CLK_SWITCH_CTRL_CNT_EN only)
// Optional feature macro: CLK_SWITCH_CTRL_CNT_EN
//
// state  | meaning
// IDLE   | ready for a request; no-op requests pulse done here
// SETTLE | sel_clk1 changed, waiting for the mux to hand over
// DWELL  | done reported, holding off the next switch
module clk_switch_ctrl
    import clk_switch_ctrl_pkg::*;
#(
    parameter int   SETTLE_CYC = 8,
    parameter int   DWELL_CYC  = 16,
    parameter logic RST_SEL    = 1'b0,
    parameter int   CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    input  logic             req_sel,
    output logic             req_ready,
    output logic             sel_clk1,
    output logic             busy,
    output logic             done
`ifdef CLK_SWITCH_CTRL_CNT_EN
    ,
    output logic [CNT_W-1:0] sw_count
`endif
);

    localparam int TMR_W = tmr_w(SETTLE_CYC, DWELL_CYC);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] DWELL_LD  =
        (DWELL_CYC > 0) ? TMR_W'(DWELL_CYC - 1) : '0;

    generate
        if (SETTLE_CYC < 1 || DWELL_CYC < 0 || CNT_W < 1) begin : g_bad_param
            $error("clk_switch_ctrl: illegal parameter value");
        end
    endgenerate

    state_e           state, state_nxt;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;
    logic             sel_nxt;
    logic             done_nxt;
    logic             cnt_inc;

    clk_sw_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        sel_nxt   = sel_clk1;
        done_nxt  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_sel == sel_clk1) begin
                        done_nxt = 1'b1;
                    end else begin
                        sel_nxt   = req_sel;
                        tmr_load  = 1'b1;
                        tmr_val   = SETTLE_LD;
                        cnt_inc   = 1'b1;
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else begin
                    done_nxt = 1'b1;
                    if (DWELL_CYC == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_val   = DWELL_LD;
                        state_nxt = DWELL;
                    end
                end
            end
            DWELL: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_clk1 <= RST_SEL;
            done     <= 1'b0;
        end else begin
            sel_clk1 <= sel_nxt;
            done     <= done_nxt;
        end
    end

`ifdef CLK_SWITCH_CTRL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_count <= '0;
        end else if (cnt_inc && (sw_count != '1)) begin
            sw_count <= sw_count + 1'b1;
        end
    end
`else
    logic unused_cnt_inc;
    assign unused_cnt_inc = cnt_inc;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
